// File: rtl/serial_pkg.sv
// Shared definitions for the serial controller: TX sequencer state encoding
// and bit positions within the status register.
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_GAP
   } tx_state_t;

   localparam int STAT_RXFULL  = 0;
   localparam int STAT_TXFULL  = 1;
   localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/serial_tx_seq.sv
// Transmit sequencer: one-byte write buffer, start/busy handshake with the
// transmitter, optional inter-frame gap and the frame-complete interrupt.
module serial_tx_seq
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TX_GAP     = 0
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  wrEn,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic                  txBusy,
   output logic                  txStart,
   output logic [DATA_WIDTH-1:0] txData,
   output logic                  txFull,
   output logic                  irqTx
);

   localparam logic [7:0] GAP_LOAD = (TX_GAP > 0) ? 8'(TX_GAP - 1) : 8'd0;

   tx_state_t             state, state_next;
   logic [7:0]            gap_cnt, gap_cnt_next;
   logic [DATA_WIDTH-1:0] tx_hold;
   logic                  irq_next;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave a value unassigned (latch).
   always_comb begin
      state_next   = state;
      gap_cnt_next = gap_cnt;
      irq_next     = 1'b0;
      case (state)
         ST_IDLE:      if (txFull) state_next = ST_START;
         ST_START:     state_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (txBusy) state_next = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (!txBusy) begin
               if (TX_GAP > 0) begin
                  state_next   = ST_GAP;
                  gap_cnt_next = GAP_LOAD;
               end else begin
                  state_next = ST_IDLE;
                  irq_next   = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == 8'd0) begin
               state_next = ST_IDLE;
               irq_next   = 1'b1;
            end else begin
               gap_cnt_next = gap_cnt - 8'd1;
            end
         end
         default:      state_next = ST_IDLE;
      endcase
   end

   assign txStart = (state == ST_START);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state   <= ST_IDLE;
         gap_cnt <= 8'd0;
         tx_hold <= '0;
         txFull  <= 1'b0;
         txData  <= '0;
         irqTx   <= 1'b0;
      end else begin
         state   <= state_next;
         gap_cnt <= gap_cnt_next;
         irqTx   <= irq_next;
         // Present the byte on entry to START so it is valid during the pulse.
         if (state == ST_IDLE && txFull) txData <= tx_hold;
         if (state == ST_START) begin
            txFull <= 1'b0;
         end else if (wrEn && !txFull) begin
            txFull  <= 1'b1;
            tx_hold <= wrData;
         end
      end
   end

endmodule

// File: rtl/serial_ctrl.sv
// SIO register controller between CPU decode and SerialRx/SerialTx.
// Optional macro SERIAL_CTRL_OVERRUN_EN enables the sticky overrun flag.
module serial_ctrl
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TX_GAP     = 0
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [DATA_WIDTH-1:0] rxData,
   input  logic                  rxReady,
   output logic [DATA_WIDTH-1:0] txData,
   output logic                  txStart,
   input  logic                  txBusy,
   input  logic                  wrEn,
   input  logic [DATA_WIDTH-1:0] wrData,
   input  logic                  rdEn,
   output logic [DATA_WIDTH-1:0] rdData,
   output logic [2:0]            status,
   output logic                  irqRx,
   output logic                  irqTx
);

   logic                  rx_prev;
   logic                  rx_edge;
   logic                  rx_full;
   logic [DATA_WIDTH-1:0] rx_hold;
   logic                  overrun;
   logic                  tx_full;

   // rx_prev resets high so a level already present at release is ignored.
   assign rx_edge = rxReady & ~rx_prev;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         rx_prev <= 1'b1;
         rx_hold <= '0;
         rx_full <= 1'b0;
         irqRx   <= 1'b0;
      end else begin
         rx_prev <= rxReady;
         irqRx   <= rx_edge;
         if (rx_edge) begin
            rx_hold <= rxData;
            rx_full <= 1'b1;
         end else if (rdEn) begin
            rx_full <= 1'b0;
         end
      end
   end

`ifdef SERIAL_CTRL_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (!resetN)                          overrun <= 1'b0;
      else if (rx_edge && rx_full && !rdEn) overrun <= 1'b1;
      else if (rdEn)                        overrun <= 1'b0;
   end
`else
   assign overrun = 1'b0;
`endif

   assign rdData = rx_hold;

   always_comb begin
      status               = '0;
      status[STAT_RXFULL]  = rx_full;
      status[STAT_TXFULL]  = tx_full;
      status[STAT_OVERRUN] = overrun;
   end

   serial_tx_seq #(
      .DATA_WIDTH (DATA_WIDTH),
      .TX_GAP     (TX_GAP)
   ) u_tx_seq (
      .clk     (clk),
      .resetN  (resetN),
      .wrEn    (wrEn),
      .wrData  (wrData),
      .txBusy  (txBusy),
      .txStart (txStart),
      .txData  (txData),
      .txFull  (tx_full),
      .irqTx   (irqTx)
   );

endmodule

// File: tb/tb_serial_ctrl.sv
// Bench for serial_ctrl: two instances (TX_GAP=0 and TX_GAP=4) driven by shared
// CPU/receiver stimulus, each with its own transmitter responder and model.
module tb_serial_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic       tx_busy  [2];
   logic       tx_start [2];
   logic [7:0] tx_data  [2];
   logic [7:0] rd_data  [2];
   logic [2:0] status   [2];
   logic       irq_rx   [2];
   logic       irq_tx   [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   serial_ctrl #(.DATA_WIDTH(8), .TX_GAP(0)) dut0 (
      .clk(clk), .resetN(reset_n), .rxData(rx_data), .rxReady(rx_ready),
      .txData(tx_data[0]), .txStart(tx_start[0]), .txBusy(tx_busy[0]),
      .wrEn(wr_en), .wrData(wr_data), .rdEn(rd_en), .rdData(rd_data[0]),
      .status(status[0]), .irqRx(irq_rx[0]), .irqTx(irq_tx[0])
   );

   serial_ctrl #(.DATA_WIDTH(8), .TX_GAP(4)) dut1 (
      .clk(clk), .resetN(reset_n), .rxData(rx_data), .rxReady(rx_ready),
      .txData(tx_data[1]), .txStart(tx_start[1]), .txBusy(tx_busy[1]),
      .wrEn(wr_en), .wrData(wr_data), .rdEn(rd_en), .rdData(rd_data[1]),
      .status(status[1]), .irqRx(irq_rx[1]), .irqTx(irq_tx[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Receive-side expectations (identical for both instances).
   bit         r_prev = 1'b1;
   bit         r_full, r_ovr, r_irq;
   logic [7:0] r_hold = 8'h00;

   // Transmit-side expectations, kept as a frame schedule per instance.
   int         m_gap [2] = '{0, 4};
   bit         m_full [2];
   bit         m_frame [2];
   logic [7:0] m_hold [2];
   logic [7:0] m_txdata [2];
   int         m_acc [2], m_idle [2], m_start [2], m_irq_at [2];
   int         m_d [2], m_len [2], m_fall [2];

   // Transmitter responder shape: fixed for directed tests, random otherwise.
   bit         fix_busy = 1'b1;
   int         busy_len = 10;

   int         obs_start [2], obs_irq [2], obs_n [2];
   logic [7:0] obs_data [2];

   task automatic cycle();
      bit         rst, rd, rr, wr, pf, exp_start, exp_irq, ovr_cond;
      logic [7:0] rxd, wd;
      rst = !reset_n; rd = rd_en; rr = rx_ready; wr = wr_en; rxd = rx_data; wd = wr_data;
      @(negedge clk);
      cyc++;

      if (rst) begin
         r_prev = 1'b1; r_hold = 8'h00; r_full = 1'b0; r_ovr = 1'b0; r_irq = 1'b0;
      end else begin
         r_irq    = rr && !r_prev;
         ovr_cond = r_irq && r_full && !rd;
         r_prev   = rr;
         if (r_irq) begin
            r_hold = rxd;
            r_full = 1'b1;
         end else if (rd) begin
            r_full = 1'b0;
         end
`ifdef SERIAL_CTRL_OVERRUN_EN
         if (ovr_cond)  r_ovr = 1'b1;
         else if (rd)   r_ovr = 1'b0;
`endif
      end

      for (int i = 0; i < 2; i++) begin
         exp_start = 1'b0;
         exp_irq   = 1'b0;
         if (rst) begin
            m_full[i] = 1'b0; m_frame[i] = 1'b0; m_idle[i] = cyc; m_txdata[i] = 8'h00;
         end else begin
            pf = m_full[i];
            if (m_frame[i] && cyc == m_start[i] + 1) m_full[i] = 1'b0;
            if (wr && !pf) begin
               m_full[i] = 1'b1; m_acc[i] = cyc; m_hold[i] = wd;
            end
            exp_start = m_full[i] && !m_frame[i] &&
                        cyc == ((m_idle[i] > m_acc[i]) ? m_idle[i] : m_acc[i]) + 1;
            if (exp_start) begin
               m_frame[i]  = 1'b1;
               m_start[i]  = cyc;
               m_txdata[i] = m_hold[i];
               m_d[i]      = fix_busy ? 0 : int'($urandom_range(2));
               m_len[i]    = fix_busy ? busy_len : int'($urandom_range(12, 2));
               m_fall[i]   = cyc + m_d[i] + m_len[i];
               m_irq_at[i] = m_fall[i] + 1 + m_gap[i];
            end
            exp_irq = m_frame[i] && !exp_start && cyc == m_irq_at[i];
            if (exp_irq) begin
               m_frame[i] = 1'b0;
               m_idle[i]  = cyc;
            end
         end

         if (tx_start[i] === 1'b1) begin
            obs_start[i] = cyc; obs_data[i] = tx_data[i]; obs_n[i]++;
         end
         if (irq_tx[i] === 1'b1) obs_irq[i] = cyc;

         check($sformatf("txStart[%0d]", i), tx_start[i], exp_start);
         check($sformatf("irqTx[%0d]", i), irq_tx[i], exp_irq);
         check($sformatf("txData[%0d]", i), tx_data[i], m_txdata[i]);
         check($sformatf("status[%0d]", i), status[i], {r_ovr, m_full[i], r_full});
         check($sformatf("rdData[%0d]", i), rd_data[i], r_hold);
         check($sformatf("irqRx[%0d]", i), irq_rx[i], r_irq);

         tx_busy[i] = m_frame[i] && cyc >= m_start[i] + m_d[i] && cyc < m_fall[i];
      end
   endtask

   int first_fall;
   int n_before;

   initial begin
      reset_n = 1'b0; rx_ready = 1'b1; rx_data = 8'h00;
      wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
      tx_busy[0] = 1'b0; tx_busy[1] = 1'b0;
      repeat (3) cycle();

      // Receiver level already high at reset release.
      reset_n = 1'b1;
      repeat (3) cycle();
      check("rx_high_at_release_full", status[0][0], 1'b0);
      rx_ready = 1'b0; cycle();
      rx_data = 8'h65; rx_ready = 1'b1; cycle();
      check("capture_65_data", rd_data[0], 8'h65);
      check("capture_65_status", status[0], 3'b001);
      check("capture_65_irq", irq_rx[0], 1'b1);
      cycle();
      check("capture_65_irq_drop", irq_rx[0], 1'b0);

      // Two captures without a read.
      rd_en = 1'b1; rx_ready = 1'b0; cycle(); rd_en = 1'b0;
      rx_data = 8'h11; rx_ready = 1'b1; cycle();
      rx_ready = 1'b0; cycle();
      rx_data = 8'h22; rx_ready = 1'b1; cycle();
      check("second_capture_data", rd_data[1], 8'h22);
`ifdef SERIAL_CTRL_OVERRUN_EN
      check("overrun_status", status[1], 3'b101);
`else
      check("overwrite_status", status[1], 3'b001);
`endif
      rd_en = 1'b1; rx_ready = 1'b0; cycle(); rd_en = 1'b0;
      check("read_clears_status", status[1], 3'b000);

      // Read coincident with a new capture.
      rx_data = 8'h44; rx_ready = 1'b1; cycle();
      rx_ready = 1'b0; cycle();
      rx_data = 8'h33; rx_ready = 1'b1; rd_en = 1'b1;
      check("coincident_old_byte", rd_data[0], 8'h44);
      cycle(); rd_en = 1'b0;
      check("coincident_status", status[0], 3'b001);
      check("coincident_data", rd_data[0], 8'h33);

      // Single frame, busy held 10 cycles.
      wr_data = 8'hA5; wr_en = 1'b1; cycle(); wr_en = 1'b0;
      cycle();
      check("tx_a5_start", tx_start[0], 1'b1);
      check("tx_a5_data", tx_data[0], 8'hA5);
      repeat (20) cycle();
      check("irq_tx_one_after_fall", obs_irq[0] - m_fall[0], 1);
      check("irq_tx_gap4_after_fall", obs_irq[1] - m_fall[1], 5);

      // Buffered write during WAIT_DONE, a dropped write, then the gap.
      wr_data = 8'h01; wr_en = 1'b1; cycle(); wr_en = 1'b0;
      n_before = obs_n[1];
      cycle();
      first_fall = m_fall[1];
      repeat (4) cycle();
      wr_data = 8'h02; wr_en = 1'b1; cycle();
      wr_data = 8'h03; cycle(); wr_en = 1'b0;
      repeat (30) cycle();
      check("gap_frames_started", obs_n[1] - n_before, 2);
      check("gap_second_data", obs_data[1], 8'h02);
      check("gap_second_spacing", obs_start[1] - first_fall, 6);

      // Reset while waiting for busy to fall.
      wr_data = 8'h5A; wr_en = 1'b1; cycle(); wr_en = 1'b0;
      repeat (5) cycle();
      reset_n = 1'b0; cycle(); reset_n = 1'b1;
      check("rst_txStart", tx_start[1], 1'b0);
      check("rst_irqTx", irq_tx[1], 1'b0);
      check("rst_txData", tx_data[1], 8'h00);
      check("rst_status", status[1], 3'b000);
      check("rst_rdData", rd_data[1], 8'h00);
      check("rst_irqRx", irq_rx[1], 1'b0);
      wr_data = 8'h77; wr_en = 1'b1; cycle(); wr_en = 1'b0;
      cycle();
      check("post_rst_start", tx_start[1], 1'b1);
      check("post_rst_data", tx_data[1], 8'h77);
      repeat (20) cycle();

      // Randomized traffic on both paths.
      fix_busy = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         reset_n = ($urandom_range(399) != 0);
         if ($urandom_range(4) == 0) rx_ready = ~rx_ready;
         rx_data = 8'($urandom);
         rd_en   = ($urandom_range(5) == 0);
         wr_en   = ($urandom_range(3) == 0);
         wr_data = 8'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
